// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Bits needed to hold 0..max_val for the starvation counter.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;

    logic            d_req;
    logic            d_we;
    logic [3:0]      d_be;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_arb_perf.sv
// rtl/mem_arb_perf.sv - grant and conflict counters, used only when MEM_ARB_PERF_EN is defined
module mem_arb_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_gnt,
    input  logic             d_gnt,
    input  logic             conflict,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_conflicts
);

    // Counters wrap freely; software takes deltas.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else begin
            if (i_gnt)    perf_i_grants  <= perf_i_grants + 1'b1;
            if (d_gnt)    perf_d_grants  <= perf_d_grants + 1'b1;
            if (conflict) perf_conflicts <= perf_conflicts + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store; MEM_ARB_PERF_EN adds counters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_conflicts
`endif
);

    localparam int              SW         = cnt_width(STARVE_MAX);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

    arb_state_t      state;
    arb_owner_t      owner;
    logic [SW-1:0]   starve_cnt;

    logic            win_d;
    logic            win_i;
    logic            req_act;
    logic            gnt_any;
    logic            rsp_act;
    logic [XLEN-1:0] sel_addr;
    logic [XLEN-1:0] sel_wdata;

    always_comb begin
        // Data wins unless fetch has been passed over STARVE_MAX times in a row.
        win_d     = bus.d_req && !(bus.i_req && (starve_cnt == STARVE_LIM));
        win_i     = bus.i_req && !win_d;
        req_act   = !reset && (state == IDLE) && (bus.i_req || bus.d_req);
        gnt_any   = req_act && bus.mem_ready;
        sel_addr  = win_d ? bus.d_addr : bus.i_addr;
        sel_wdata = win_d ? bus.d_wdata : '0;

        bus.mem_req   = req_act;
        bus.mem_we    = req_act && win_d && bus.d_we;
        bus.mem_be    = !req_act ? 4'h0 : (win_d ? bus.d_be : 4'hF);
        bus.mem_addr  = req_act ? sel_addr : '0;
        bus.mem_wdata = req_act ? sel_wdata : '0;
        bus.i_gnt     = gnt_any && win_i;
        bus.d_gnt     = gnt_any && win_d;

        // Responses seen while idle are leftovers from before a reset.
        rsp_act       = !reset && (state == WAIT_RSP) && bus.mem_rvalid;
        bus.i_rvalid  = rsp_act && (owner == OWN_I);
        bus.d_rvalid  = rsp_act && (owner == OWN_D);
        bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
        end else begin
            if (!bus.i_req || bus.i_gnt) begin
                starve_cnt <= '0;
            end else if (bus.d_gnt && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        state <= WAIT_RSP;
                        owner <= win_d ? OWN_D : OWN_I;
                    end
                end
                WAIT_RSP: begin
                    if (bus.mem_rvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic conflict;
    assign conflict = !reset && (state == IDLE) && bus.i_req && bus.d_req;

    mem_arb_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk            (clk),
        .reset          (reset),
        .i_gnt          (bus.i_gnt),
        .d_gnt          (bus.d_gnt),
        .conflict       (conflict),
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench with transaction-level reference model
module tb_mem_port_arbiter;

    localparam int XLEN       = 32;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0] perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    mem_port_arbiter #(
        .XLEN       (XLEN),
        .STARVE_MAX (STARVE_MAX)
`ifdef MEM_ARB_PERF_EN
        ,
        .CNT_W      (CNT_W)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: busy flag, owner of the outstanding access, fetch pass-over streak.
    bit  m_busy;
    bit  m_own_d;
    int  m_streak;
    int  m_pi, m_pd, m_pc;

    // Stimulus state: requesters hold until granted, memory answers after a latency.
    bit              c_i_act, c_d_act, c_d_we;
    logic [31:0]     c_i_addr, c_d_addr, c_d_wdata;
    logic [3:0]      c_d_be;
    int              mem_lat;
    bit              k_dir;
    int              n_grants;
    logic [9:0]      order;
    logic [31:0]     drv_rdata;
    bit              drv_rvalid;

    task automatic step(input bit rst_v);
        bit          ireq, dreq, rdy;
        bit          e_mreq, e_we, e_ig, e_dg, e_iv, e_dv, d_wins;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wdata, e_ir, e_dr;

        @(posedge clk);
        #1;
        reset = rst_v;
        if (!c_i_act && (k_dir || $urandom_range(0, 2) == 0)) begin
            c_i_act  = 1'b1;
            c_i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!c_d_act && (k_dir || $urandom_range(0, 2) == 0)) begin
            c_d_act   = 1'b1;
            c_d_we    = $urandom_range(0, 1);
            c_d_be    = 4'($urandom_range(1, 15));
            c_d_addr  = $urandom;
            c_d_wdata = $urandom;
        end
        drv_rdata  = $urandom;
        drv_rvalid = 1'b0;
        if (mem_lat == 1) begin
            drv_rvalid = 1'b1;
            mem_lat    = 0;
        end else if (mem_lat > 1) begin
            mem_lat--;
        end else if (!k_dir && $urandom_range(0, 7) == 0) begin
            drv_rvalid = 1'b1;
        end
        rdy = k_dir ? 1'b1 : ($urandom_range(0, 3) != 0);

        bus.i_req      = c_i_act;
        bus.i_addr     = c_i_addr;
        bus.d_req      = c_d_act;
        bus.d_we       = c_d_we;
        bus.d_be       = c_d_be;
        bus.d_addr     = c_d_addr;
        bus.d_wdata    = c_d_wdata;
        bus.mem_ready  = rdy;
        bus.mem_rvalid = drv_rvalid;
        bus.mem_rdata  = drv_rdata;
        ireq = c_i_act;
        dreq = c_d_act;

        @(negedge clk);
        cyc++;
        {e_mreq, e_we, e_ig, e_dg, e_iv, e_dv} = '0;
        e_be = '0; e_addr = '0; e_wdata = '0; e_ir = '0; e_dr = '0;
        d_wins = 1'b0;
        if (!rst_v && !m_busy) begin
            d_wins = dreq && !(ireq && m_streak >= STARVE_MAX);
            e_mreq = ireq || dreq;
            if (d_wins) begin
                e_we = c_d_we; e_be = c_d_be; e_addr = c_d_addr; e_wdata = c_d_wdata;
            end else if (ireq) begin
                e_be = 4'hF; e_addr = c_i_addr;
            end
            e_ig = e_mreq && rdy && !d_wins;
            e_dg = e_mreq && rdy && d_wins;
        end else if (!rst_v && drv_rvalid) begin
            e_iv = !m_own_d;
            e_dv = m_own_d;
            e_ir = m_own_d ? 32'h0 : drv_rdata;
            e_dr = m_own_d ? drv_rdata : 32'h0;
        end

        check("ctl", {54'h0, bus.mem_req, bus.mem_we, bus.mem_be, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid},
              {54'h0, e_mreq, e_we, e_be, e_ig, e_dg, e_iv, e_dv});
        check("mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, {e_addr, e_wdata});
        check("rdata", {bus.i_rdata, bus.d_rdata}, {e_ir, e_dr});
`ifdef MEM_ARB_PERF_EN
        check("perf_i", 64'(perf_i_grants), 64'(rst_v ? 0 : m_pi));
        check("perf_d", 64'(perf_d_grants), 64'(rst_v ? 0 : m_pd));
        check("perf_c", 64'(perf_conflicts), 64'(rst_v ? 0 : m_pc));
`endif

        if (rst_v) begin
            m_busy = 0; m_streak = 0; m_pi = 0; m_pd = 0; m_pc = 0;
        end else begin
            if (!m_busy && ireq && dreq) m_pc++;
            if (m_busy && drv_rvalid) m_busy = 0;
            if (e_ig || e_dg) begin
                m_busy   = 1;
                m_own_d  = e_dg;
                mem_lat  = k_dir ? 1 : $urandom_range(1, 3);
                order    = {order[8:0], e_ig};
                n_grants++;
            end
            if (e_ig) begin m_pi++; c_i_act = 1'b0; end
            if (e_dg) begin m_pd++; c_d_act = 1'b0; end
            if (!ireq || e_ig)                           m_streak = 0;
            else if (e_dg && m_streak < STARVE_MAX)      m_streak++;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        m_busy = 0; m_own_d = 0; m_streak = 0; m_pi = 0; m_pd = 0; m_pc = 0;
        c_i_act = 0; c_d_act = 0; mem_lat = 0; n_grants = 0; order = '0;

        // Starvation order with both requesters held high and a one-cycle memory.
        k_dir = 1'b1;
        step(1'b1);
        step(1'b1);
        n_grants = 0;
        for (int i = 0; i < 100 && n_grants < 10; i++) step(1'b0);
        check("grant_order", 64'(order), 64'(10'b0000100001));
        step(1'b0);
`ifdef MEM_ARB_PERF_EN
        check("perf_d_after10", 64'(perf_d_grants), 64'd8);
        check("perf_i_after10", 64'(perf_i_grants), 64'd2);
        check("perf_c_after10", 64'(perf_conflicts), 64'd10);
`endif

        // Reset during an access, then the late response must not be routed.
        step(1'b0);
        mem_lat = 2;
        step(1'b1);
        step(1'b0);

        k_dir = 1'b0;
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 199) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
